// File: rtl/spi_frame_pkg.sv
// rtl/spi_frame_pkg.sv - shared types, constants and CRC7 byte step for the SPI frame decoder
package spi_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARG  = 2'd1,
        CRC  = 2'd2
    } FrameState;

    localparam int          FRAME_LEN     = 6;
    localparam int          ARG_BYTES     = FRAME_LEN - 2;
    localparam logic [1:0]  START_PATTERN = 2'b01;
    localparam logic [6:0]  CRC7_POLY     = 7'h09;

    // Bit-serial CRC7 over one byte, MSB first, unrolled into a single cycle.
    function automatic logic [6:0] crc7Byte(input logic [6:0] crcIn, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crcIn;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ CRC7_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_crc7.sv
// rtl/spi_crc7.sv - byte-wide CRC7 accumulator with clear
module spi_crc7
    import spi_frame_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       clear,
    input  logic       update,
    input  logic [7:0] data,
    output logic [6:0] crc
);

    // A clear coinciding with an update restarts the sum from that byte.
    always_ff @(posedge CLK) begin
        if (RST) begin
            crc <= '0;
        end else if (update) begin
            crc <= crc7Byte(clear ? 7'h00 : crc, data);
        end else if (clear) begin
            crc <= '0;
        end
    end

endmodule

// File: rtl/spi_frame_decoder.sv
// rtl/spi_frame_decoder.sv - 6-byte SPI command frame decoder; CRC check under SPI_FRAME_CRC7_EN
module spi_frame_decoder
    import spi_frame_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS,
    input  logic [7:0]  Buffer,
    input  logic        Changed,
    output logic [5:0]  CmdIndex,
    output logic [31:0] CmdArg,
    output logic        CmdValid,
    output logic        CmdError,
    output logic        Abort,
    output logic        Busy
);

    localparam logic [1:0] LAST_ARG = 2'(ARG_BYTES - 1);

    FrameState   state, stateNext;
    logic [1:0]  argCount, argCountNext;
    logic [5:0]  indexAcc, indexAccNext;
    logic [31:0] argAcc, argAccNext;
    logic        validNext, abortNext;
    logic        crcOk;
    logic        take;

    assign take = Changed && !CS;
    assign Busy = (state != IDLE);

`ifdef SPI_FRAME_CRC7_EN
    logic [6:0] crcValue;
    logic       errorNext;
    logic       crcUpdate;

    assign crcUpdate = take && ((state == IDLE && Buffer[7:6] == START_PATTERN) || state == ARG);

    spi_crc7 crcUnit (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (state == IDLE),
        .update (crcUpdate),
        .data   (Buffer),
        .crc    (crcValue)
    );

    assign crcOk = (crcValue == Buffer[7:1]) && Buffer[0];
`else
    assign crcOk    = 1'b1;
    assign CmdError = 1'b0;
`endif

    always_comb begin
        stateNext    = state;
        argCountNext = argCount;
        indexAccNext = indexAcc;
        argAccNext   = argAcc;
        validNext    = 1'b0;
        abortNext    = 1'b0;
`ifdef SPI_FRAME_CRC7_EN
        errorNext    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (take && Buffer[7:6] == START_PATTERN) begin
                    stateNext    = ARG;
                    argCountNext = 2'd0;
                    indexAccNext = Buffer[5:0];
                end
            end
            ARG: begin
                if (CS) begin
                    stateNext = IDLE;
                    abortNext = 1'b1;
                end else if (Changed) begin
                    argAccNext   = {argAcc[23:0], Buffer};
                    argCountNext = argCount + 2'd1;
                    if (argCount == LAST_ARG) stateNext = CRC;
                end
            end
            CRC: begin
                if (CS) begin
                    stateNext = IDLE;
                    abortNext = 1'b1;
                end else if (Changed) begin
                    stateNext = IDLE;
                    if (crcOk) validNext = 1'b1;
`ifdef SPI_FRAME_CRC7_EN
                    else errorNext = 1'b1;
`endif
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            argCount <= '0;
            indexAcc <= '0;
            argAcc   <= '0;
            CmdIndex <= '0;
            CmdArg   <= '0;
            CmdValid <= 1'b0;
            Abort    <= 1'b0;
`ifdef SPI_FRAME_CRC7_EN
            CmdError <= 1'b0;
`endif
        end else begin
            state    <= stateNext;
            argCount <= argCountNext;
            indexAcc <= indexAccNext;
            argAcc   <= argAccNext;
            CmdValid <= validNext;
            Abort    <= abortNext;
`ifdef SPI_FRAME_CRC7_EN
            CmdError <= errorNext;
`endif
            // Published fields move only on an accepted frame.
            if (validNext) begin
                CmdIndex <= indexAcc;
                CmdArg   <= argAcc;
            end
        end
    end

endmodule

// File: doc/spi_frame_decoder.md
SPI_FRAME_DECODER -- requirements
Module: spi_frame_decoder

Interface
REQ-001 The clock and reset SHALL be: one clock `CLK`; reset `RST` is synchronous and active-high.
REQ-002 Port `CLK`  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port `RST`  in  1  synchronous active-high reset.
REQ-004 Port `CS`  in  1  chip-select from the upstream SPI byte buffer, CLK-synchronous; 1 = deselected (frame abort), 0 = transfer active.
REQ-005 Port `Buffer`  in  8  received byte from the upstream SPI byte buffer; bit 7 = first transmitted command bit.
REQ-006 Port `Changed`  in  1  one-CLK pulse meaning `Buffer` holds a new byte; back-to-back pulses SHALL be legal.
REQ-007 Port `CmdIndex`  out  6  command index of the last accepted frame.
REQ-008 Port `CmdArg`  out  32  argument of the last accepted frame; the first argument byte is bits 31:24.
REQ-009 Port `CmdValid`  out  1  one-cycle pulse when a frame is accepted.
REQ-010 Port `CmdError`  out  1  one-cycle pulse when a frame is rejected.
REQ-011 Port `Abort`  out  1  one-cycle pulse when a frame is cut short by `CS`=1.
REQ-012 Port `Busy`  out  1  high whenever the state is not IDLE.

Function
REQ-013 Frame format SHALL be 6 bytes: start byte, four argument bytes MSB-first, then the CRC byte.
- Start byte: bits 7:6 = 01, bits 5:0 = index.
- CRC byte: bits 7:1 = CRC7, bit 0 = end bit (1).
REQ-014 States SHALL be IDLE, ARG, CRC.
- IDLE -> ARG on a `Changed` byte with bits 7:6 = 01.
- ARG -> CRC after the 4th argument byte.
- CRC -> IDLE on the CRC byte.
REQ-015 In IDLE, bytes whose bits 7:6 are not 01 (e.g. 0xFF fill) SHALL be ignored without any pulse.
REQ-016 A 2-bit counter SHALL count argument bytes 0..3 and clear on entering ARG.
REQ-017 `CmdValid` or `CmdError` SHALL pulse exactly one cycle, in the cycle after the CLK edge that samples the CRC byte's `Changed`.
REQ-018 `CmdIndex` and `CmdArg` SHALL update only together with `CmdValid` and hold until the next `CmdValid`; partial frames never alter them.
REQ-019 `CS`=1 in ARG or CRC SHALL force IDLE and pulse `Abort` next cycle; no `CmdValid`/`CmdError` is produced for that frame.
REQ-020 `CS`=1 in the same cycle as `Changed` SHALL take priority; the byte is dropped.
REQ-021 `CS`=1 in IDLE SHALL have no effect other than blocking byte acceptance.
REQ-022 `CmdValid`, `CmdError` and `Abort` SHALL be mutually exclusive in any cycle.

Reset
REQ-023 `RST` SHALL force IDLE, counter 0, CRC accumulator 0 and all outputs 0 at the next edge, including mid-frame; `RST` overrides `CS` and `Changed`.

Configuration
REQ-024 With `SPI_FRAME_CRC7_EN` defined, the block SHALL check the frame.
- CRC7 (poly x^7+x^3+1, init 0) is computed over the 5 preceding bytes and compared to CRC byte bits 7:1; the end bit must be 1.
- Any mismatch gives `CmdError` instead of `CmdValid`.
REQ-025 Without `SPI_FRAME_CRC7_EN`, the CRC byte SHALL be accepted unconditionally, `CmdError` SHALL be tied 0 and no CRC logic shall be synthesized.

Structure
REQ-026 The shared package `spi_frame_pkg` SHALL hold:
- the state enum;
- FRAME_LEN = 6;
- START_PATTERN = 2'b01;
- CRC7_POLY = 7'h09.
REQ-027 CRC7 SHALL be a sub-module `spi_crc7` (byte-wide update, clear, 7-bit result), instantiated only under `SPI_FRAME_CRC7_EN`.

Verification
REQ-028 Bytes 0x40 00 00 00 00 95 -> `CmdValid` 1 cycle, `CmdIndex`=0, `CmdArg`=0x00000000, no `CmdError`.
REQ-029 Bytes 0xFF 0xFF 0x48 00 00 01 AA 87, fed on consecutive `Changed` cycles -> the 0xFF bytes are ignored; `CmdIndex`=8, `CmdArg`=0x000001AA.
REQ-030 Bytes 0x40 00 00 00 00 00 -> with the EN macro: `CmdError` pulse, outputs unchanged from the prior frame; without it: `CmdValid`, index 0.
REQ-031 Bytes 0x51 00 00, then `CS`=1 -> `Abort` pulse, `Busy`=0. A following frame 0x51 00 00 00 00 55 decodes to index 17, arg 0.
REQ-032 `RST` asserted after 0x4D 12 -> all outputs 0, IDLE. A following frame 0x4D 00 00 00 00 0D decodes to index 13.
REQ-033 `CS`=1 coincident with the CRC byte's `Changed` -> `Abort` only, no `CmdValid`.
